// File: rtl/pc_gen.sv
// Fetch program counter: steps on accepted fetch, redirects on trap/mret/branch, saves EPC.
// All outputs registered, redirect visible one cycle after the event; stall or !fetch_ready holds state, redirects override both.
module pc_gen #(
    parameter int                   DATAWIDTH    = 32,
    parameter logic [DATAWIDTH-1:0] RESET_VECTOR = DATAWIDTH'(32'h0000_0000),
    parameter logic [DATAWIDTH-1:0] TRAP_VECTOR  = DATAWIDTH'(32'h0000_0100),
    parameter int                   INST_BYTES   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 fetch_ready,
    input  logic                 br_taken,
    input  logic [DATAWIDTH-1:0] br_target,
    input  logic                 trap,
    input  logic [DATAWIDTH-1:0] trap_pc,
    input  logic                 mret,
    output logic [DATAWIDTH-1:0] pc_out,
    output logic                 pc_valid,
    output logic [DATAWIDTH-1:0] epc_out,
    output logic                 flush,
    output logic                 misalign
);

    localparam logic [DATAWIDTH-1:0] INC        = DATAWIDTH'(INST_BYTES);
    localparam logic [DATAWIDTH-1:0] ALIGN_MASK = DATAWIDTH'(INST_BYTES - 1);

    logic [DATAWIDTH-1:0] pc_nxt;
    logic [DATAWIDTH-1:0] epc_nxt;
    logic                 flush_nxt;
    logic                 misalign_nxt;
    logic                 target_misaligned;

    // INST_BYTES is a power of two, so the modulo reduces to a low-bit mask.
    assign target_misaligned = |(br_target & ALIGN_MASK);

    always_comb begin
        pc_nxt       = pc_out;
        epc_nxt      = epc_out;
        flush_nxt    = 1'b0;
        misalign_nxt = 1'b0;
        if (trap) begin
            pc_nxt    = TRAP_VECTOR;
            epc_nxt   = trap_pc;
            flush_nxt = 1'b1;
        end else if (mret) begin
            pc_nxt    = epc_out;
            flush_nxt = 1'b1;
        end else if (br_taken && target_misaligned) begin
            pc_nxt       = TRAP_VECTOR;
            epc_nxt      = br_target;
            flush_nxt    = 1'b1;
            misalign_nxt = 1'b1;
        end else if (br_taken) begin
            pc_nxt    = br_target;
            flush_nxt = 1'b1;
        end else if (pc_valid && !stall && fetch_ready) begin
            // Unsigned add wraps modulo 2^DATAWIDTH with no flag.
            pc_nxt = pc_out + INC;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_out   <= RESET_VECTOR;
            pc_valid <= 1'b0;
            epc_out  <= '0;
            flush    <= 1'b0;
            misalign <= 1'b0;
        end else begin
            pc_out   <= pc_nxt;
            pc_valid <= 1'b1;
            epc_out  <= epc_nxt;
            flush    <= flush_nxt;
            misalign <= misalign_nxt;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: default, INST_BYTES=2 and DATAWIDTH=8 instances share stimulus.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst, stall, fetch_ready, br_taken, trap, mret;
    logic [31:0] br_target, trap_pc;

    logic [31:0] pc_a, epc_a, pc_b, epc_b;
    logic        v_a, fl_a, mi_a, v_b, fl_b, mi_b, v_c, fl_c, mi_c;
    logic [7:0]  pc_c, epc_c;

    always #5 clk = ~clk;

    pc_gen u_dut_a (
        .clk(clk), .rst(rst), .stall(stall), .fetch_ready(fetch_ready),
        .br_taken(br_taken), .br_target(br_target), .trap(trap), .trap_pc(trap_pc),
        .mret(mret), .pc_out(pc_a), .pc_valid(v_a), .epc_out(epc_a),
        .flush(fl_a), .misalign(mi_a)
    );

    pc_gen #(.INST_BYTES(2)) u_dut_b (
        .clk(clk), .rst(rst), .stall(stall), .fetch_ready(fetch_ready),
        .br_taken(br_taken), .br_target(br_target), .trap(trap), .trap_pc(trap_pc),
        .mret(mret), .pc_out(pc_b), .pc_valid(v_b), .epc_out(epc_b),
        .flush(fl_b), .misalign(mi_b)
    );

    pc_gen #(.DATAWIDTH(8)) u_dut_c (
        .clk(clk), .rst(rst), .stall(stall), .fetch_ready(fetch_ready),
        .br_taken(br_taken), .br_target(br_target[7:0]), .trap(trap), .trap_pc(trap_pc[7:0]),
        .mret(mret), .pc_out(pc_c), .pc_valid(v_c), .epc_out(epc_c),
        .flush(fl_c), .misalign(mi_c)
    );

    typedef struct {
        int          w;
        logic [31:0] pc;
        logic        v;
        logic [31:0] epc;
        logic        fl;
        logic        mi;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, want, $time);
    endtask

    task automatic idle();
        rst = 1'b0; stall = 1'b0; fetch_ready = 1'b1;
        br_taken = 1'b0; trap = 1'b0; mret = 1'b0;
        br_target = '0; trap_pc = '0;
    endtask

    // Inputs are already set; queue the expected post-edge outputs, clock, then score.
    task automatic step(input int w, input logic [31:0] pc, input logic v,
                        input logic [31:0] epc, input logic fl, input logic mi);
        exp_t e;
        exp_q.push_back('{w, pc, v, epc, fl, mi});
        @(posedge clk);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            case (e.w)
                0: begin
                    chk("a_pc", pc_a, e.pc);       chk("a_valid", {31'd0, v_a}, {31'd0, e.v});
                    chk("a_epc", epc_a, e.epc);    chk("a_flush", {31'd0, fl_a}, {31'd0, e.fl});
                    chk("a_misalign", {31'd0, mi_a}, {31'd0, e.mi});
                end
                1: begin
                    chk("b_pc", pc_b, e.pc);       chk("b_valid", {31'd0, v_b}, {31'd0, e.v});
                    chk("b_epc", epc_b, e.epc);    chk("b_flush", {31'd0, fl_b}, {31'd0, e.fl});
                    chk("b_misalign", {31'd0, mi_b}, {31'd0, e.mi});
                end
                default: begin
                    chk("c_pc", {24'd0, pc_c}, e.pc);   chk("c_valid", {31'd0, v_c}, {31'd0, e.v});
                    chk("c_epc", {24'd0, epc_c}, e.epc); chk("c_flush", {31'd0, fl_c}, {31'd0, e.fl});
                    chk("c_misalign", {31'd0, mi_c}, {31'd0, e.mi});
                end
            endcase
        end
        idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        idle();
        @(negedge clk);

        // Default instance: reset release and sequential fetch
        rst = 1; step(0, 32'h0, 0, 32'h0, 0, 0);
        rst = 1; step(0, 32'h0, 0, 32'h0, 0, 0);
        step(0, 32'h0,  1, 32'h0, 0, 0);
        step(0, 32'h4,  1, 32'h0, 0, 0);
        step(0, 32'h8,  1, 32'h0, 0, 0);
        step(0, 32'hC,  1, 32'h0, 0, 0);
        step(0, 32'h10, 1, 32'h0, 0, 0);

        // Stall 3 cycles, then fetch_ready low 2 cycles
        for (int i = 0; i < 3; i++) begin stall = 1; step(0, 32'h10, 1, 32'h0, 0, 0); end
        for (int i = 0; i < 2; i++) begin fetch_ready = 0; step(0, 32'h10, 1, 32'h0, 0, 0); end
        step(0, 32'h14, 1, 32'h0, 0, 0);

        // Branch during stall redirects anyway
        stall = 1; br_taken = 1; br_target = 32'h200; step(0, 32'h200, 1, 32'h0, 1, 0);
        stall = 1; step(0, 32'h200, 1, 32'h0, 0, 0);
        step(0, 32'h204, 1, 32'h0, 0, 0);

        // Trap beats branch on the same edge, then mret
        trap = 1; trap_pc = 32'h40; br_taken = 1; br_target = 32'h80;
        step(0, 32'h100, 1, 32'h40, 1, 0);
        step(0, 32'h104, 1, 32'h40, 0, 0);
        mret = 1; step(0, 32'h40, 1, 32'h40, 1, 0);
        step(0, 32'h44, 1, 32'h40, 0, 0);

        // Misaligned target becomes a trap
        br_taken = 1; br_target = 32'h202; step(0, 32'h100, 1, 32'h202, 1, 1);
        step(0, 32'h104, 1, 32'h202, 0, 0);

        // Back-to-back redirects, then mret over a concurrent branch
        br_taken = 1; br_target = 32'h300; step(0, 32'h300, 1, 32'h202, 1, 0);
        br_taken = 1; br_target = 32'h400; step(0, 32'h400, 1, 32'h202, 1, 0);
        mret = 1; br_taken = 1; br_target = 32'h500; step(0, 32'h202, 1, 32'h202, 1, 0);

        // 32-bit wrap-around
        br_taken = 1; br_target = 32'hFFFF_FFFC; step(0, 32'hFFFF_FFFC, 1, 32'h202, 1, 0);
        step(0, 32'h0, 1, 32'h202, 0, 0);

        // Reset beats trap on the same edge
        rst = 1; trap = 1; trap_pc = 32'h88; step(0, 32'h0, 0, 32'h0, 0, 0);
        step(0, 32'h0, 1, 32'h0, 0, 0);

        // INST_BYTES=2: 0x202 is aligned
        rst = 1; step(1, 32'h0, 0, 32'h0, 0, 0);
        step(1, 32'h0, 1, 32'h0, 0, 0);
        br_taken = 1; br_target = 32'h202; step(1, 32'h202, 1, 32'h0, 1, 0);
        step(1, 32'h204, 1, 32'h0, 0, 0);
        br_taken = 1; br_target = 32'h203; step(1, 32'h100, 1, 32'h203, 1, 1);

        // DATAWIDTH=8: wrap, then reset over trap
        rst = 1; step(2, 32'h0, 0, 32'h0, 0, 0);
        step(2, 32'h0, 1, 32'h0, 0, 0);
        br_taken = 1; br_target = 32'hFC; step(2, 32'hFC, 1, 32'h0, 1, 0);
        step(2, 32'h00, 1, 32'h0, 0, 0);
        trap = 1; trap_pc = 32'h24; step(2, 32'h00, 1, 32'h24, 1, 0);
        rst = 1; trap = 1; trap_pc = 32'h30; step(2, 32'h0, 0, 32'h0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the fetch stage: it holds the current fetch address and steps it by one instruction when fetch accepts it. It also handles branch redirects, traps to a fixed vector, and return-from-trap through an internal exception-PC register. The block sits between the execute/branch logic and instruction memory, and drives the fetch address and the wrong-path flush for downstream stages.

## Interface
Parameters:
- DATAWIDTH, 32, width of all address ports and registers
- RESET_VECTOR, 32'h0000_0000, value loaded into pc_out by reset
- TRAP_VECTOR, 32'h0000_0100, fetch address taken on a trap or on a misaligned branch target
- INST_BYTES, 4, sequential increment; legal values are 2 and 4

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  reset, synchronous and active-high
- stall  in  1  pipeline hazard hold
- fetch_ready  in  1  instruction memory accepts the current pc_out this cycle
- br_taken  in  1  branch/jump redirect request
- br_target  in  DATAWIDTH  redirect address
- trap  in  1  exception request
- trap_pc  in  DATAWIDTH  address of the faulting instruction
- mret  in  1  return from trap
- pc_out  out  DATAWIDTH  current fetch address
- pc_valid  out  1  pc_out is a valid fetch request
- epc_out  out  DATAWIDTH  saved exception PC
- flush  out  1  one-cycle pulse: pc_out was redirected, so kill younger in-flight instructions
- misalign  out  1  one-cycle pulse: a branch target was misaligned and was converted into a trap

## Operation
- All outputs are registered. On each edge the block evaluates the following cases in strict priority order:
  1. rst: pc_out=RESET_VECTOR, pc_valid=0, epc_out=0, flush=0, misalign=0.
  2. trap: pc_out=TRAP_VECTOR, epc_out=trap_pc, flush=1.
  3. mret: pc_out=epc_out (the value before this edge), flush=1.
  4. br_taken with br_target misaligned (br_target mod INST_BYTES ≠ 0): pc_out=TRAP_VECTOR, epc_out=br_target, flush=1, misalign=1.
  5. br_taken with an aligned target: pc_out=br_target, flush=1.
  6. pc_valid=0: pc_valid becomes 1 and pc_out is unchanged. This is the single bubble after reset.
  7. stall=1 or fetch_ready=0: hold all state.
  8. Otherwise: pc_out = pc_out + INST_BYTES, computed modulo 2^DATAWIDTH.
- Cases 2–8 set pc_valid=1. Cases 6–8 set flush=0. misalign is 1 only in case 4.
- Redirects (cases 2–5) take effect regardless of stall and fetch_ready. A fetch request that was pending and not accepted is abandoned.
- When events coincide, the lower-priority events are dropped with no side effect. For example, trap together with br_taken leaves epc_out = trap_pc.
- epc_out changes only on reset, on a trap, or on a misaligned branch.

## Timing
- Redirect latency is 1 cycle. If an event is sampled at edge k, then pc_out, flush and misalign show the result in the cycle after edge k.
- flush is high for exactly one cycle per redirect. Back-to-back redirects produce back-to-back flush pulses.
- Reset sequence:
  - While rst is high: pc_out=RESET_VECTOR and pc_valid=0.
  - First edge with rst low: pc_valid goes to 1. pc_out does not advance on this edge.
  - Next edge with fetch_ready=1 and stall=0: pc_out = RESET_VECTOR+INST_BYTES.
- Wrap-around: with pc_out = 2^DATAWIDTH − INST_BYTES, an advance gives 0. No flag is raised.
- Reset asserted mid-operation overrides any concurrent redirect on the same edge.
- There are no combinational paths from inputs to outputs.

## Test plan
- Reset release with fetch_ready=1, stall=0 and default parameters: pc_out reads 0, 0, 4, 8, 12 on successive cycles, with pc_valid 0→1 after the first edge with rst low.
- stall=1 for 3 cycles at pc_out=0x10, then fetch_ready=0 for 2 cycles: pc_out holds 0x10 for 5 cycles, then advances to 0x14. flush stays 0 throughout.
- br_taken=1 with br_target=0x200 while stall=1: next cycle pc_out=0x200 and flush=1 for one cycle; then pc_out goes to 0x204 once the stall is released.
- trap=1 with trap_pc=0x40 and br_taken=1 (br_target=0x80) on the same edge: pc_out=0x100 and epc_out=0x40. Later mret=1 gives pc_out=0x40 and flush=1.
- br_taken=1 with br_target=0x202: pc_out=0x100, epc_out=0x202, misalign=1 and flush=1, each for one cycle. Repeat with INST_BYTES=2: the target is aligned, so pc_out=0x202 and misalign=0.
- DATAWIDTH=8 with br_target=0xFC: pc_out reads 0xFC, then 0x00 (wrap). Assert rst on the same edge as trap: pc_out=RESET_VECTOR, epc_out=0, pc_valid=0.
